// File: rtl/compare_scan_ctrl.sv
// compare_scan_ctrl: two-operand capture FSM with registered compare flags and a 4-digit anode scan
module compare_scan_ctrl #(
  parameter int REFRESH_DIV = 100000,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sw_data,
  input  logic       load_btn,
  input  logic       clear_btn,
  input  logic       GT_sw,
  input  logic       LT_sw,
  input  logic       EQ_sw,
  output logic [3:0] bin_num,
  output logic [3:0] Led,
  output logic [1:0] stage,
  output logic       cmp_valid
);
  typedef enum logic [1:0] {GET_A = 2'b00, GET_B = 2'b01, SHOW = 2'b10, BAD = 2'b11} state_t;
  localparam int CW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
  state_t r_state, w_next;
  logic [SYNC_STAGES-1:0] r_load_sync, r_clear_sync;
  logic r_load_q, r_clear_q, w_load, w_clear;
  logic [3:0] r_a, r_b, w_val;
  logic r_g, r_l, r_e, r_valid, w_show, w_tc;
  logic [CW-1:0] r_cnt;
  logic [1:0] r_idx;
  assign w_load  = r_load_sync[SYNC_STAGES-1] & ~r_load_q;
  assign w_clear = r_clear_sync[SYNC_STAGES-1] & ~r_clear_q;
  assign w_tc    = r_cnt == CW'(REFRESH_DIV - 1);
  // button synchronizers plus edge flops so a held button yields one pulse
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_load_sync  <= '0;
      r_clear_sync <= '0;
      r_load_q     <= 1'b0;
      r_clear_q    <= 1'b0;
    end else begin
      r_load_sync  <= {r_load_sync[SYNC_STAGES-2:0], load_btn};
      r_clear_sync <= {r_clear_sync[SYNC_STAGES-2:0], clear_btn};
      r_load_q     <= r_load_sync[SYNC_STAGES-1];
      r_clear_q    <= r_clear_sync[SYNC_STAGES-1];
    end
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= GET_A;
    else     r_state <= w_next;
  // next state: clear wins over load; the unused code recovers to GET_A
  always_comb begin
    w_next = r_state;
    w_next = w_clear                        ? GET_A :
             (r_state == GET_A && w_load)   ? GET_B :
             (r_state == GET_B && w_load)   ? SHOW  :
             (r_state == BAD)               ? GET_A : r_state;
  end
  // operand capture and compare flags, taken against the raw switches at the B capture edge
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_a <= '0; r_b <= '0; r_g <= 1'b0; r_l <= 1'b0; r_e <= 1'b0; r_valid <= 1'b0;
    end else if (w_clear) begin
      r_a <= '0; r_b <= '0; r_g <= 1'b0; r_l <= 1'b0; r_e <= 1'b0; r_valid <= 1'b0;
    end else if (w_load && r_state == GET_A) begin
      r_a <= sw_data;
    end else if (w_load && r_state == GET_B) begin
      r_b     <= sw_data;
      r_g     <= r_a > sw_data;
      r_l     <= r_a < sw_data;
      r_e     <= r_a == sw_data;
      r_valid <= 1'b1;
    end
  // free-running digit scan, independent of the FSM and of clear
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else begin
      r_cnt <= w_tc ? '0 : r_cnt + 1'b1;
      if (w_tc) r_idx <= r_idx + 1'b1;
    end
  // slot content: decide visibility and value for the currently scanned digit
  always_comb begin
    w_show = 1'b0;
    w_val  = '0;
    w_show = r_idx == 2'd0 ? (r_state == SHOW && $onehot({GT_sw, LT_sw, EQ_sw}) && !(EQ_sw && !r_e)) :
             r_idx == 2'd1 ? r_state == SHOW :
             r_idx == 2'd2 ? (r_state == GET_B || r_state == SHOW) :
                             (r_state == GET_A || r_state == GET_B);
    w_val  = r_idx == 2'd0 ? (GT_sw ? (r_g ? r_a : r_b) : LT_sw ? (r_l ? r_a : r_b) : r_a) :
             r_idx == 2'd1 ? r_b :
             r_idx == 2'd2 ? r_a : sw_data;
  end
  assign Led       = w_show ? ~(4'b0001 << r_idx) : 4'hF;
  assign bin_num   = w_show ? w_val : 4'h0;
  assign stage     = r_state;
  assign cmp_valid = r_valid;
endmodule

// File: tb/tb_compare_scan_ctrl.sv
// tb_compare_scan_ctrl: directed checks of capture, compare modes, scan timing and reset
module tb_compare_scan_ctrl;
  logic clk = 1'b0, clk_en = 1'b0, rst = 1'b0;
  logic [3:0] sw_data = 4'h5;
  logic load_btn = 1'b0, clear_btn = 1'b0, GT_sw = 1'b0, LT_sw = 1'b0, EQ_sw = 1'b0;
  logic [3:0] bin_num, Led;
  logic [1:0] stage;
  logic cmp_valid;
  int n_tests = 0, n_fail = 0, cyc = 0;
  compare_scan_ctrl #(.REFRESH_DIV(4), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .sw_data(sw_data), .load_btn(load_btn), .clear_btn(clear_btn),
    .GT_sw(GT_sw), .LT_sw(LT_sw), .EQ_sw(EQ_sw), .bin_num(bin_num), .Led(Led),
    .stage(stage), .cmp_valid(cmp_valid)
  );
  always #5 clk = clk_en ? ~clk : clk;
  // reference scan position: rising edges since reset release
  always @(posedge clk or posedge rst)
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  function automatic int scan_idx();
    return (cyc / 4) % 4;
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic go_idx(input int n);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (scan_idx() == n) break;
    end
    #1;
    chk("scan_reach", 32'(scan_idx()), 32'(n));
  endtask
  task automatic pulse(input logic ld, input logic cl, input logic [3:0] v);
    sw_data = v; load_btn = ld; clear_btn = cl;
    repeat (3) @(negedge clk);
    #1;
  endtask
  task automatic release_btns();
    load_btn = 1'b0; clear_btn = 1'b0;
    repeat (4) @(negedge clk);
  endtask
  task automatic modes(input logic g, input logic l, input logic e);
    GT_sw = g; LT_sw = l; EQ_sw = e;
  endtask
  initial begin
    #1 rst = 1'b1;
    #1;
    chk("rst_led", Led, 4'hF);
    chk("rst_bin", bin_num, 4'h0);
    chk("rst_stage", stage, 2'b00);
    chk("rst_valid", cmp_valid, 1'b0);
    clk_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sw_data = 4'hA;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      #1;
      chk("idle_scan", {Led, bin_num}, scan_idx() == 3 ? 8'h7A : 8'hF0);
    end
    pulse(1'b1, 1'b0, 4'h9);
    chk("capA_stage", stage, 2'b01);
    release_btns();
    go_idx(2);
    chk("capA_show", {Led, bin_num}, 8'hB9);
    pulse(1'b1, 1'b0, 4'h4);
    chk("capB_stage", stage, 2'b10);
    chk("capB_valid", cmp_valid, 1'b1);
    release_btns();
    modes(1'b1, 1'b0, 1'b0);
    go_idx(0);
    chk("gt_9_4", {Led, bin_num}, 8'hE9);
    modes(1'b0, 1'b1, 1'b0);
    #1 chk("lt_9_4", {Led, bin_num}, 8'hE4);
    modes(1'b0, 1'b0, 1'b1);
    #1 chk("eq_9_4", {Led, bin_num}, 8'hF0);
    modes(1'b1, 1'b1, 1'b0);
    #1 chk("gt_lt_blank", {Led, bin_num}, 8'hF0);
    modes(1'b0, 1'b0, 1'b0);
    #1 chk("none_blank", {Led, bin_num}, 8'hF0);
    go_idx(1);
    chk("show_b", {Led, bin_num}, 8'hD4);
    go_idx(3);
    chk("show_sw_blank", {Led, bin_num}, 8'hF0);
    pulse(1'b0, 1'b1, 4'h0);
    chk("clr_stage", stage, 2'b00);
    chk("clr_valid", cmp_valid, 1'b0);
    release_btns();
    pulse(1'b1, 1'b0, 4'h7);
    release_btns();
    pulse(1'b1, 1'b0, 4'h7);
    chk("eq77_stage", stage, 2'b10);
    release_btns();
    modes(1'b0, 1'b0, 1'b1);
    go_idx(0);
    chk("eq_7_7", {Led, bin_num}, 8'hE7);
    modes(1'b1, 1'b0, 1'b0);
    #1 chk("gt_7_7", {Led, bin_num}, 8'hE7);
    modes(1'b0, 1'b1, 1'b0);
    #1 chk("lt_7_7", {Led, bin_num}, 8'hE7);
    modes(1'b0, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 4'h0);
    release_btns();
    sw_data = 4'h3; load_btn = 1'b1;
    repeat (50) @(negedge clk);
    #1 chk("hold_stage", stage, 2'b01);
    release_btns();
    go_idx(2);
    chk("hold_a", {Led, bin_num}, 8'hB3);
    pulse(1'b1, 1'b1, 4'h6);
    chk("ldclr_stage", stage, 2'b00);
    chk("ldclr_valid", cmp_valid, 1'b0);
    release_btns();
    pulse(1'b1, 1'b0, 4'h9);
    release_btns();
    pulse(1'b1, 1'b0, 4'h4);
    release_btns();
    modes(1'b1, 1'b0, 1'b0);
    go_idx(0);
    chk("pre_rst_gt", {Led, bin_num}, 8'hE9);
    rst = 1'b1;
    #1;
    chk("mid_rst_out", {Led, bin_num}, 8'hF0);
    chk("mid_rst_stage", stage, 2'b00);
    chk("mid_rst_valid", cmp_valid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
